// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage memory access block.
// Holds the aluop encodings (ME_* memory ops plus the ALU ops the stage sees),
// the FSM state type and small decode helpers used by mem_access and mem_load_ext.
package mem_access_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [ALU_OP_W-1:0]   aluop_t;
    typedef logic [REG_W-1:0]      reg_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam aluop_t ME_NOP_OP  = 8'b0000_0000;
    localparam aluop_t ALU_OR_OP  = 8'b0010_0101;
    localparam aluop_t ALU_ADD_OP = 8'b0010_0000;
    localparam aluop_t ME_LB_OP   = 8'b1110_0000;
    localparam aluop_t ME_LH_OP   = 8'b1110_0001;
    localparam aluop_t ME_LW_OP   = 8'b1110_0011;
    localparam aluop_t ME_LBU_OP  = 8'b1110_0100;
    localparam aluop_t ME_LHU_OP  = 8'b1110_0101;
    localparam aluop_t ME_SB_OP   = 8'b1110_1000;
    localparam aluop_t ME_SH_OP   = 8'b1110_1001;
    localparam aluop_t ME_SW_OP   = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic is_mem_op(input aluop_t op);
        case (op)
            ME_LB_OP, ME_LH_OP, ME_LW_OP, ME_LBU_OP, ME_LHU_OP,
            ME_SB_OP, ME_SH_OP, ME_SW_OP: is_mem_op = 1'b1;
            default:                      is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input aluop_t op);
        case (op)
            ME_SB_OP, ME_SH_OP, ME_SW_OP: is_store_op = 1'b1;
            default:                      is_store_op = 1'b0;
        endcase
    endfunction

    // Index of the final byte of the transfer (byte count minus one).
    function automatic logic [1:0] last_byte_idx(input aluop_t op);
        case (op)
            ME_LH_OP, ME_LHU_OP, ME_SH_OP: last_byte_idx = 2'd1;
            ME_LW_OP, ME_SW_OP:            last_byte_idx = 2'd3;
            default:                       last_byte_idx = 2'd0;
        endcase
    endfunction

    // Little-endian byte lane select.
    function automatic logic [7:0] byte_lane(input reg_t w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_lane = w[7:0];
            2'd1:    byte_lane = w[15:8];
            2'd2:    byte_lane = w[23:16];
            default: byte_lane = w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// mem_load_ext: sign/zero extension of the assembled load buffer.
// Ports: aluop (memory op code), load_buf (little-endian assembled bytes), load_data (extended result).
// Purely combinational; zero latency, no flow control.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  aluop_t aluop,
    input  reg_t   load_buf,
    output reg_t   load_data
);

    always_comb begin
        load_data = load_buf;
        case (aluop)
            ME_LB_OP:  load_data = {{24{load_buf[7]}},  load_buf[7:0]};
            ME_LBU_OP: load_data = {24'd0,              load_buf[7:0]};
            ME_LH_OP:  load_data = {{16{load_buf[15]}}, load_buf[15:0]};
            ME_LHU_OP: load_data = {16'd0,              load_buf[15:0]};
            default:   load_data = load_buf;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage that performs loads/stores one byte at a time over a byte-wide RAM port.
// Ports: EX/MEM inputs (mem_*), byte RAM port (ram_*), MEM/WB outputs (wb_*), stallreq.
// Non-memory ops pass through combinationally; memory ops stall the pipe until a one-cycle DONE.
module mem_access
    import mem_access_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t mem_wd,
    input  logic      mem_wreg,
    input  reg_t      mem_wdata,
    input  reg_t      mem_mem_addr,
    input  aluop_t    mem_aluop,
    output logic      ram_req,
    output logic      ram_we,
    output reg_t      ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    input  logic      ram_done,
    output reg_addr_t wb_wd,
    output logic      wb_wreg,
    output reg_t      wb_wdata,
    output logic      stallreq
);

    state_t     state;
    logic [1:0] byte_idx;
    reg_t       load_buf;
    reg_t       load_data;

    logic       mem_op;
    logic       store_op;
    logic [1:0] last_idx;
    logic [1:0] next_idx;

    assign mem_op   = is_mem_op(mem_aluop);
    assign store_op = is_store_op(mem_aluop);
    assign last_idx = last_byte_idx(mem_aluop);
    assign next_idx = byte_idx + 2'd1;

    // ram_req is registered high for the whole of ACCESS, so a ram_done seen
    // outside ACCESS is never acted on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_idx  <= 2'd0;
            load_buf  <= '0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        state     <= ST_ACCESS;
                        byte_idx  <= 2'd0;
                        load_buf  <= '0;
                        ram_req   <= 1'b1;
                        ram_we    <= store_op;
                        ram_addr  <= mem_mem_addr;
                        ram_wdata <= byte_lane(mem_wdata, 2'd0);
                    end
                end
                ST_ACCESS: begin
                    if (ram_done) begin
                        load_buf[{byte_idx, 3'b000} +: 8] <= ram_rdata;
                        if (byte_idx == last_idx) begin
                            state    <= ST_DONE;
                            byte_idx <= 2'd0;
                            ram_req  <= 1'b0;
                            ram_we   <= 1'b0;
                        end else begin
                            byte_idx  <= next_idx;
                            // Address wraps modulo 2^32; misalignment needs no care.
                            ram_addr  <= mem_mem_addr + {30'd0, next_idx};
                            ram_wdata <= byte_lane(mem_wdata, next_idx);
                        end
                    end
                end
                // DONE always returns to IDLE so the held op is not relaunched.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_load_ext u_load_ext (
        .aluop     (mem_aluop),
        .load_buf  (load_buf),
        .load_data (load_data)
    );

    always_comb begin
        stallreq = 1'b0;
        wb_wd    = '0;
        wb_wreg  = 1'b0;
        wb_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    stallreq = 1'b1;
                end else begin
                    wb_wd    = mem_wd;
                    wb_wreg  = mem_wreg;
                    wb_wdata = mem_wdata;
                end
            end
            ST_ACCESS: stallreq = 1'b1;
            ST_DONE: begin
                if (!store_op) begin
                    wb_wd    = mem_wd;
                    wb_wreg  = 1'b1;
                    wb_wdata = load_data;
                end
            end
            default: stallreq = 1'b0;
        endcase
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL declare ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL declare inputs from the EX/MEM register: mem_wd  in  5  dest reg; mem_wreg  in  1  write enable; mem_wdata  in  32  ALU result / store data; mem_mem_addr  in  32  byte address; mem_aluop  in  `AluOpBus  memory op code.
REQ-003 SHALL declare RAM port: ram_req  out  1  byte request; ram_we  out  1  1=write; ram_addr  out  32  byte address; ram_wdata  out  8  store byte; ram_rdata  in  8  load byte; ram_done  in  1  current byte complete.
REQ-004 SHALL declare outputs: wb_wd  out  5; wb_wreg  out  1; wb_wdata  out  32 (all to MEM/WB register and forwarding); stallreq  out  1  pipeline stall request.

Function
REQ-005 SHALL treat ME_LB/LH/LW/LBU/LHU/SB/SH/SW as memory ops and all other aluop values, including ME_NOP_OP, as non-memory ops.
REQ-006 Non-memory op in IDLE: wb_wd/wb_wreg/wb_wdata SHALL equal mem_wd/mem_wreg/mem_wdata combinationally, with stallreq=0 and zero added latency.
REQ-007 FSM states SHALL be IDLE, ACCESS, DONE. Transitions: IDLE -> ACCESS when a memory op is present; ACCESS -> DONE when ram_done=1 on the last byte; DONE -> IDLE unconditionally after exactly one cycle.
REQ-008 Byte count SHALL be 1 for B/BU/SB, 2 for H/HU/SH, and 4 for W/SW; byte index k SHALL run from 0 to count-1.
REQ-009 In ACCESS, the block SHALL drive ram_req=1, ram_addr=mem_mem_addr+k (mod 2^32, wrap permitted), ram_we=1 for stores, and ram_wdata=mem_wdata[8k+7:8k]; little-endian ordering SHALL apply.
REQ-010 Per-byte handshake: ram_req and address SHALL stay stable until ram_done=1 is sampled; ram_done MAY arrive in the first request cycle. On done the block SHALL capture ram_rdata into load byte k and increment k. ram_done while ram_req=0 SHALL be ignored.
REQ-011 Misaligned addresses SHALL be legal and SHALL need no special handling.
REQ-012 stallreq SHALL be 1 in IDLE with a memory op present and throughout ACCESS, and 0 in DONE and for non-memory ops.
REQ-013 During IDLE-with-memory-op and ACCESS, wb_wreg SHALL be 0, wb_wd SHALL be 0, and wb_wdata SHALL be 0.
REQ-014 In DONE, a load SHALL present wb_wd=mem_wd, wb_wreg=1, and wb_wdata=assembled data: B/H sign-extended, BU/HU zero-extended, W unmodified. A store SHALL present wb_wreg=0.
REQ-015 Latency with single-cycle ram_done SHALL be: stallreq high for count+1 cycles, DONE on cycle count+1.
REQ-016 Inputs are guaranteed stable while stallreq=1, because upstream holds. The block SHALL NOT re-launch the same op in DONE.
REQ-017 ram_req SHALL be 0 in IDLE and DONE.

Reset
REQ-018 rst=1 SHALL force asynchronously: state=IDLE, k=0, load buffer=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-019 Reset mid-ACCESS SHALL abandon the transfer. Partial load data SHALL be discarded, and a partially written store SHALL NOT be resumed.
REQ-020 After reset release, a memory op present SHALL start a fresh access at byte 0.

Structure
REQ-021 ME_* op encodings, `AluOpBus, `RegBus, `RegAddrBus, and the state encodings SHALL reside in defines.vh.
REQ-022 One combinational sub-module, mem_load_ext, SHALL perform load sign/zero extension from aluop and the 32-bit buffer. The FSM, counter, and RAM port SHALL remain in mem_access.

Verification
REQ-023 Non-memory pass-through: aluop=ADD, wd=5, wreg=1, wdata=0x1234 -> same-cycle wb outputs equal the inputs, stallreq=0, ram_req never 1.
REQ-024 LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, immediate done -> addresses 0x100..0x103 in order; DONE presents wb_wdata=0x12345678, wb_wreg=1; stallreq high 5 cycles.
REQ-025 LB/LBU at 0x7 with byte 0x80, ram_done delayed 3 cycles -> address held stable; LB gives 0xFFFFFF80, LBU gives 0x00000080.
REQ-026 SH data 0xAABBCCDD at 0xFFFFFFFF -> writes 0xDD at 0xFFFFFFFF and 0xCC at 0x00000000 (wrap); wb_wreg=0 in DONE.
REQ-027 Reset asserted mid-LW after 2 bytes -> ram_req drops immediately, state IDLE; re-issued LW restarts at the base address and returns the correct word.
REQ-028 Back-to-back LHU then ADD -> LHU DONE cycle followed by the ADD passing through in the next cycle with stallreq=0.
